// File: rtl/riot_io_timer.sv
// RIOT-class peripheral: N_PORTS bidirectional 8-bit ports with direction
// registers, a prescaled interval timer with post-expiry fast count, and an
// edge-detect interrupt on one selectable port pin.
module riot_io_timer #(
    parameter int N_PORTS     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_PORT   = 0,
    parameter int EDGE_BIT    = 7,
    parameter int DIV0        = 1,
    parameter int DIV1        = 8,
    parameter int DIV2        = 64,
    parameter int DIV3        = 1024
) (
    input  logic                 phi2,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 we_n,
    input  logic [4:0]           A,
    input  logic [7:0]           DI,
    output logic [7:0]           DO,
    output logic                 OE,
    output logic                 irq_n,
    output logic [8*N_PORTS-1:0] PO,
    output logic [8*N_PORTS-1:0] PDDR,
    input  logic [8*N_PORTS-1:0] PI
);

    localparam int PRE_W = 16;
    localparam int EDGE_IDX = 8 * EDGE_PORT + EDGE_BIT;

    typedef logic [PRE_W-1:0] pre_t;

    // Prescale reload value (ratio minus one) for each rate select code.
    function automatic pre_t divReload(input logic [1:0] sel);
        case (sel)
            2'd0:    divReload = pre_t'(DIV0 - 1);
            2'd1:    divReload = pre_t'(DIV1 - 1);
            2'd2:    divReload = pre_t'(DIV2 - 1);
            default: divReload = pre_t'(DIV3 - 1);
        endcase
    endfunction

    logic [8*N_PORTS-1:0] sync_q [SYNC_STAGES];
    logic [8*N_PORTS-1:0] piSync;
    logic [8*N_PORTS-1:0] effective;

    logic [8*N_PORTS-1:0] po_q, po_d;
    logic [8*N_PORTS-1:0] ddr_q, ddr_d;
    logic [7:0]           timer_q, timer_d;
    pre_t                 pre_q, pre_d;
    logic [1:0]           divSel_q, divSel_d;
    logic                 fast_q, fast_d;
    logic                 tFlag_q, tFlag_d;
    logic                 tIe_q, tIe_d;
    logic                 eFlag_q, eFlag_d;
    logic                 eIe_q, eIe_d;
    logic                 ePol_q, ePol_d;
    logic                 ePrev_q;
    logic [7:0]           do_q, do_d;
    logic                 oe_q, oe_d;
    logic                 irqN_q, irqN_d;

    logic       accRead, accWrite;
    logic       timerWrite, timerRead, flagRead, edgeCtlWrite, portWrite;
    logic       expire, edgeCur, edgeHit;
    logic [7:0] portData, portDdr, rdData;

    assign accRead      = cs & we_n;
    assign accWrite     = cs & ~we_n;
    assign portWrite    = accWrite & ~A[4];
    assign timerWrite   = accWrite & A[4] & ~A[2];
    assign edgeCtlWrite = accWrite & A[4] & A[2];
    assign timerRead    = accRead & A[4] & ~A[2] & ~A[0];
    assign flagRead     = accRead & A[4] & A[0];

    assign piSync    = sync_q[SYNC_STAGES-1];
    assign effective = (ddr_q & po_q) | (~ddr_q & piSync);
    assign edgeCur   = effective[EDGE_IDX];
    assign edgeHit   = (edgeCur != ePrev_q) && (edgeCur == ePol_q);

    // Pad inputs are asynchronous, so pass them through a flop chain first.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= PI;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Select the addressed port; unimplemented ports leave both values at zero.
    always_comb begin
        portData = 8'h00;
        portDdr  = 8'h00;
        for (int p = 0; p < N_PORTS; p++) begin
            if (A[3:1] == 3'(p)) begin
                portData = effective[8*p +: 8];
                portDdr  = ddr_q[8*p +: 8];
            end
        end
    end

    // Read data mux; a port read returns the pin as driven or as sampled.
    always_comb begin
        rdData = 8'h00;
        if (!A[4]) rdData = A[0] ? portDdr : portData;
        else if (A[0]) rdData = {tFlag_q, eFlag_q, 6'b000000};
        else if (!A[2]) rdData = timer_q;
    end

    // Next state: ports, timer with its set-beats-clear flag, edge detector, bus output.
    always_comb begin
        po_d     = po_q;
        ddr_d    = ddr_q;
        timer_d  = timer_q;
        pre_d    = pre_q;
        divSel_d = divSel_q;
        fast_d   = fast_q;
        tFlag_d  = tFlag_q;
        tIe_d    = tIe_q;
        eFlag_d  = eFlag_q;
        eIe_d    = eIe_q;
        ePol_d   = ePol_q;
        expire   = 1'b0;

        if (portWrite) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (A[3:1] == 3'(p)) begin
                    if (A[0]) ddr_d[8*p +: 8] = DI;
                    else      po_d[8*p +: 8]  = DI;
                end
            end
        end

        if (fast_q || pre_q == '0) begin
            timer_d = timer_q - 8'd1;
            expire  = (timer_q == 8'h00);
            if (!fast_q) pre_d = divReload(divSel_q);
        end else begin
            pre_d = pre_q - pre_t'(1);
        end

        if (timerRead) begin
            tIe_d   = A[3];
            tFlag_d = 1'b0;
        end
        if (expire) begin
            tFlag_d = 1'b1;
            fast_d  = 1'b1;
        end
        if (timerWrite) begin
            timer_d  = DI;
            divSel_d = A[1:0];
            pre_d    = divReload(A[1:0]);
            tIe_d    = A[3];
            tFlag_d  = 1'b0;
            fast_d   = 1'b0;
        end

        if (flagRead) eFlag_d = 1'b0;
        if (edgeHit)  eFlag_d = 1'b1;
        if (edgeCtlWrite) begin
            ePol_d = A[0];
            eIe_d  = A[1];
        end

        do_d   = accRead ? rdData : 8'h00;
        oe_d   = accRead;
        irqN_d = ~((tFlag_d & tIe_d) | (eFlag_d & eIe_d));
    end

    // State registers; irq_n is itself a flop so it never glitches.
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            po_q     <= '0;
            ddr_q    <= '0;
            timer_q  <= 8'h00;
            pre_q    <= divReload(2'd3);
            divSel_q <= 2'd3;
            fast_q   <= 1'b0;
            tFlag_q  <= 1'b0;
            tIe_q    <= 1'b0;
            eFlag_q  <= 1'b0;
            eIe_q    <= 1'b0;
            ePol_q   <= 1'b0;
            ePrev_q  <= 1'b0;
            do_q     <= 8'h00;
            oe_q     <= 1'b0;
            irqN_q   <= 1'b1;
        end else begin
            po_q     <= po_d;
            ddr_q    <= ddr_d;
            timer_q  <= timer_d;
            pre_q    <= pre_d;
            divSel_q <= divSel_d;
            fast_q   <= fast_d;
            tFlag_q  <= tFlag_d;
            tIe_q    <= tIe_d;
            eFlag_q  <= eFlag_d;
            eIe_q    <= eIe_d;
            ePol_q   <= ePol_d;
            ePrev_q  <= edgeCur;
            do_q     <= do_d;
            oe_q     <= oe_d;
            irqN_q   <= irqN_d;
        end
    end

    assign PO    = po_q;
    assign PDDR  = ddr_q;
    assign DO    = do_q;
    assign OE    = oe_q;
    assign irq_n = irqN_q;

endmodule

// File: tb/tb_riot_io_timer.sv
// Testbench for riot_io_timer with three ports: directed scenarios plus
// randomized bus traffic compared against a cycle-level behavioural model.
module tb_riot_io_timer;

    localparam int NP = 3;
    localparam int SS = 2;

    logic        phi2 = 1'b0;
    logic        rst  = 1'b1;
    logic        cs   = 1'b0;
    logic        we_n = 1'b1;
    logic [4:0]  A    = 5'h00;
    logic [7:0]  DI   = 8'h00;
    logic [7:0]  DO;
    logic        OE;
    logic        irq_n;
    logic [23:0] PO;
    logic [23:0] PDDR;
    logic [23:0] PI   = 24'h000000;

    int nChecks = 0;
    int nFails  = 0;

    riot_io_timer #(
        .N_PORTS(NP), .SYNC_STAGES(SS), .EDGE_PORT(0), .EDGE_BIT(7),
        .DIV0(1), .DIV1(8), .DIV2(64), .DIV3(1024)
    ) dut (
        .phi2(phi2), .rst(rst), .cs(cs), .we_n(we_n), .A(A), .DI(DI),
        .DO(DO), .OE(OE), .irq_n(irq_n), .PO(PO), .PDDR(PDDR), .PI(PI)
    );

    always #5 phi2 = ~phi2;

    // Reference model state.
    int          cyc    = 0;
    int          wrCyc  = 0;
    int          wrVal  = 0;
    int          wrDiv  = 1024;
    logic [7:0]  mPO [NP];
    logic [7:0]  mDDR [NP];
    logic [23:0] piHist [SS];
    logic        mTFlag = 1'b0, mTIe = 1'b0, mEFlag = 1'b0, mEIe = 1'b0;
    logic        mEPol = 1'b0, mPrevEff = 1'b0;
    logic [7:0]  mDO = 8'h00;
    logic        mOE = 1'b0;
    logic        mIrqN = 1'b1;

    function automatic int divOf(input logic [1:0] sel);
        case (sel)
            2'd0:    return 1;
            2'd1:    return 8;
            2'd2:    return 64;
            default: return 1024;
        endcase
    endfunction

    // Timer value k edges after a load of v with ratio d, in closed form.
    function automatic int timerAt(input int k, input int v, input int d);
        int nE;
        nE = (v + 1) * d;
        if (k < nE) return v - k / d;
        return 255 - ((k - nE) % 256);
    endfunction

    // True when the decrement on edge k is a 0x00 -> 0xFF wrap.
    function automatic bit expiresAt(input int k, input int v, input int d);
        int nE;
        nE = (v + 1) * d;
        return (k >= nE) && (((k - nE) % 256) == 0);
    endfunction

    // Model advances once per rising edge from the bus values seen there.
    always @(posedge phi2) begin : model
        int          k, idx;
        logic [23:0] syncV;
        logic [7:0]  eff [NP];
        logic [7:0]  rd;
        logic        curEdge, expNow, hit, tWr, tRd, fRd, eWr;
        logic        nTFlag, nTIe, nEFlag, nEIe;
        cyc <= cyc + 1;
        if (rst) begin
            wrCyc <= cyc + 1; wrVal <= 0; wrDiv <= 1024;
            for (int p = 0; p < NP; p++) begin mPO[p] <= 8'h00; mDDR[p] <= 8'h00; end
            for (int s = 0; s < SS; s++) piHist[s] <= 24'h0;
            mTFlag <= 1'b0; mTIe <= 1'b0; mEFlag <= 1'b0; mEIe <= 1'b0;
            mEPol <= 1'b0; mPrevEff <= 1'b0; mDO <= 8'h00; mOE <= 1'b0; mIrqN <= 1'b1;
        end else begin
            k     = cyc + 1 - wrCyc;
            syncV = piHist[SS-1];
            for (int p = 0; p < NP; p++) eff[p] = (mDDR[p] & mPO[p]) | (~mDDR[p] & syncV[8*p +: 8]);
            curEdge = eff[0][7];
            idx  = int'(A[3:1]);
            tWr  = cs & ~we_n & A[4] & ~A[2];
            eWr  = cs & ~we_n & A[4] & A[2];
            tRd  = cs & we_n & A[4] & ~A[2] & ~A[0];
            fRd  = cs & we_n & A[4] & A[0];
            expNow = expiresAt(k, wrVal, wrDiv);
            rd = 8'h00;
            if (cs && we_n) begin
                if (!A[4]) begin
                    if (idx < NP) rd = A[0] ? mDDR[idx] : eff[idx];
                end else if (A[0]) rd = {mTFlag, mEFlag, 6'b000000};
                else if (!A[2]) rd = 8'(timerAt(k - 1, wrVal, wrDiv));
            end
            mDO <= rd;
            mOE <= cs & we_n;
            nTFlag = mTFlag; nTIe = mTIe;
            if (tWr) begin
                nTFlag = 1'b0; nTIe = A[3];
                wrCyc <= cyc + 1; wrVal <= int'(DI); wrDiv <= divOf(A[1:0]);
            end else begin
                if (tRd) begin nTIe = A[3]; nTFlag = 1'b0; end
                if (expNow) nTFlag = 1'b1;
            end
            hit = (curEdge != mPrevEff) && (curEdge == mEPol);
            nEFlag = mEFlag;
            if (fRd) nEFlag = 1'b0;
            if (hit) nEFlag = 1'b1;
            nEIe = mEIe;
            if (eWr) begin nEIe = A[1]; mEPol <= A[0]; end
            mPrevEff <= curEdge;
            if (cs && !we_n && !A[4] && idx < NP) begin
                if (A[0]) mDDR[idx] <= DI;
                else      mPO[idx]  <= DI;
            end
            piHist[0] <= PI;
            for (int s = 1; s < SS; s++) piHist[s] <= piHist[s-1];
            mTFlag <= nTFlag; mTIe <= nTIe; mEFlag <= nEFlag; mEIe <= nEIe;
            mIrqN <= ~((nTFlag & nTIe) | (nEFlag & nEIe));
        end
    end

    // Drive one bus cycle from a falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic c, input logic w, input logic [4:0] a, input logic [7:0] d);
        cs = c; we_n = w; A = a; DI = d;
        @(negedge phi2);
        cs = 1'b0; we_n = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge phi2);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
        nChecks++; if (DO !== 8'h00) begin nFails++; $display("[TB] FAIL reset_do: got %h expected 00", DO); end
        nChecks++; if (OE !== 1'b0) begin nFails++; $display("[TB] FAIL reset_oe: got %b expected 0", OE); end
        nChecks++; if (irq_n !== 1'b1) begin nFails++; $display("[TB] FAIL reset_irq: got %b expected 1", irq_n); end
        nChecks++; if (PO !== 24'h0 || PDDR !== 24'h0) begin nFails++; $display("[TB] FAIL reset_ports: got PO %h PDDR %h expected 0", PO, PDDR); end
        applyStimulus(1'b1, 1'b0, 5'h00, 8'h5A);
        applyStimulus(1'b1, 1'b0, 5'h01, 8'hFF);
        applyStimulus(1'b1, 1'b0, 5'h18, 8'h00);
        applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
        nChecks++; if (irq_n !== mIrqN || irq_n !== 1'b0) begin nFails++; $display("[TB] FAIL pre_reset_irq: got %b expected 0", irq_n); end
        cs = 1'b1; we_n = 1'b1; A = 5'h00;
        @(posedge phi2); #1;
        nChecks++; if (OE !== 1'b1 || DO !== mDO) begin nFails++; $display("[TB] FAIL inflight_read: got OE %b DO %h expected 1 %h", OE, DO, mDO); end
        rst = 1'b1; #1;
        nChecks++; if (OE !== 1'b0 || DO !== 8'h00) begin nFails++; $display("[TB] FAIL async_oe: got OE %b DO %h expected 0 00", OE, DO); end
        nChecks++; if (irq_n !== 1'b1) begin nFails++; $display("[TB] FAIL async_irq: got %b expected 1", irq_n); end
        nChecks++; if (PO !== 24'h0 || PDDR !== 24'h0) begin nFails++; $display("[TB] FAIL async_ports: got PO %h PDDR %h expected 0", PO, PDDR); end
        @(negedge phi2); cs = 1'b0;
        @(negedge phi2); rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
        nChecks++; if (DO !== mDO || OE !== mOE || irq_n !== mIrqN) begin nFails++; $display("[TB] FAIL post_reset: got %h %b %b expected %h %b %b", DO, OE, irq_n, mDO, mOE, mIrqN); end
    endtask

    task automatic test_ports;
        logic [4:0] a;
        PI = {8'h00, 8'h3C, 8'h00};
        applyStimulus(1'b1, 1'b0, 5'h03, 8'hF0);
        applyStimulus(1'b1, 1'b0, 5'h02, 8'hA5);
        repeat (SS) applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 5'h02, 8'h00);
        nChecks++; if (DO !== 8'hAC || DO !== mDO) begin nFails++; $display("[TB] FAIL port1_read: got %h expected AC", DO); end
        applyStimulus(1'b1, 1'b1, 5'h03, 8'h00);
        nChecks++; if (DO !== 8'hF0) begin nFails++; $display("[TB] FAIL ddr1_read: got %h expected F0", DO); end
        applyStimulus(1'b1, 1'b0, 5'h0A, 8'h77);
        nChecks++; if (OE !== 1'b0 || DO !== 8'h00) begin nFails++; $display("[TB] FAIL write_no_oe: got OE %b DO %h expected 0 00", OE, DO); end
        applyStimulus(1'b1, 1'b1, 5'h0A, 8'h00);
        nChecks++; if (DO !== 8'h00 || OE !== 1'b1) begin nFails++; $display("[TB] FAIL port5_read: got DO %h OE %b expected 00 1", DO, OE); end
        for (int i = 0; i < 60; i++) begin
            a = {1'b0, 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1))};
            if ($urandom_range(0, 3) == 0) PI = 24'($urandom);
            if ($urandom_range(0, 1) == 0) applyStimulus(1'b1, 1'b0, a, 8'($urandom));
            else applyStimulus(1'b1, 1'b1, a, 8'h00);
            nChecks++; if (DO !== mDO || OE !== mOE) begin nFails++; $display("[TB] FAIL rand_port A=%h: got %h %b expected %h %b", a, DO, OE, mDO, mOE); end
            nChecks++; if (PO !== {mPO[2], mPO[1], mPO[0]} || PDDR !== {mDDR[2], mDDR[1], mDDR[0]}) begin
                nFails++; $display("[TB] FAIL rand_latches: got PO %h PDDR %h", PO, PDDR);
            end
        end
    endtask

    task automatic test_timer;
        applyStimulus(1'b1, 1'b0, 5'h19, 8'h03);
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
            nChecks++; if (irq_n !== ((k == 32) ? 1'b0 : 1'b1) || irq_n !== mIrqN) begin
                nFails++; $display("[TB] FAIL div8_irq cycle %0d: got %b expected %b", k, irq_n, (k == 32) ? 1'b0 : 1'b1);
            end
        end
        applyStimulus(1'b1, 1'b1, 5'h18, 8'h00);
        nChecks++; if (DO !== 8'hFF || irq_n !== 1'b1) begin nFails++; $display("[TB] FAIL timer_read_ff: got %h irq %b expected FF 1", DO, irq_n); end
        applyStimulus(1'b1, 1'b1, 5'h10, 8'h00);
        nChecks++; if (DO !== 8'hFE || DO !== mDO) begin nFails++; $display("[TB] FAIL fast_fe: got %h expected FE", DO); end
        applyStimulus(1'b1, 1'b1, 5'h10, 8'h00);
        nChecks++; if (DO !== 8'hFD || DO !== mDO) begin nFails++; $display("[TB] FAIL fast_fd: got %h expected FD", DO); end
        applyStimulus(1'b1, 1'b0, 5'h19, 8'h01);
        repeat (15) applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 5'h19, 8'h20);
        nChecks++; if (irq_n !== 1'b1 || irq_n !== mIrqN) begin nFails++; $display("[TB] FAIL rewrite_expiry_irq: got %b expected 1", irq_n); end
        applyStimulus(1'b1, 1'b1, 5'h11, 8'h00);
        nChecks++; if (DO[7] !== 1'b0 || DO !== mDO) begin nFails++; $display("[TB] FAIL rewrite_expiry_flag: got %h expected bit7 0", DO); end
        applyStimulus(1'b1, 1'b0, 5'h18, 8'h00);
        applyStimulus(1'b1, 1'b1, 5'h18, 8'h00);
        nChecks++; if (DO !== 8'h00 || irq_n !== 1'b0) begin nFails++; $display("[TB] FAIL read_in_expiry: got %h irq %b expected 00 0", DO, irq_n); end
        applyStimulus(1'b1, 1'b1, 5'h11, 8'h00);
        nChecks++; if (DO[7] !== 1'b1 || DO !== mDO) begin nFails++; $display("[TB] FAIL read_in_expiry_flag: got %h expected bit7 1", DO); end
        for (int t = 0; t < 6; t++) begin
            logic [1:0] sel;
            logic [7:0] v;
            sel = 2'($urandom_range(0, 1));
            v   = (sel == 2'd0) ? 8'($urandom_range(0, 60)) : 8'($urandom_range(0, 6));
            applyStimulus(1'b1, 1'b0, {1'b1, 1'($urandom_range(0, 1)), 1'b0, sel}, v);
            for (int c = 0; c < 70; c++) begin
                case ($urandom_range(0, 9))
                    0:       applyStimulus(1'b1, 1'b1, {1'b1, 1'($urandom_range(0, 1)), 3'b000}, 8'h00);
                    1:       applyStimulus(1'b1, 1'b1, 5'h11, 8'h00);
                    default: applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
                endcase
                nChecks++; if (DO !== mDO || OE !== mOE || irq_n !== mIrqN) begin
                    nFails++; $display("[TB] FAIL rand_timer: got %h %b %b expected %h %b %b", DO, OE, irq_n, mDO, mOE, mIrqN);
                end
            end
        end
    endtask

    task automatic test_edge;
        applyStimulus(1'b1, 1'b0, 5'h13, 8'hFF);
        applyStimulus(1'b1, 1'b0, 5'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 5'h01, 8'h00);
        PI = 24'h000000;
        repeat (SS + 1) applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 5'h11, 8'h00);
        applyStimulus(1'b1, 1'b0, 5'h17, 8'h00);
        nChecks++; if (irq_n !== 1'b1) begin nFails++; $display("[TB] FAIL edge_idle_irq: got %b expected 1", irq_n); end
        PI[7] = 1'b1;
        for (int c = 1; c <= SS + 1; c++) begin
            applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
            nChecks++; if (irq_n !== ((c == SS + 1) ? 1'b0 : 1'b1) || irq_n !== mIrqN) begin
                nFails++; $display("[TB] FAIL rise_irq cycle %0d: got %b", c, irq_n);
            end
        end
        applyStimulus(1'b1, 1'b1, 5'h11, 8'h00);
        nChecks++; if (DO !== 8'h40 || irq_n !== 1'b1) begin nFails++; $display("[TB] FAIL edge_flag_read: got %h irq %b expected 40 1", DO, irq_n); end
        PI[7] = 1'b0;
        repeat (SS + 2) applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
        nChecks++; if (irq_n !== 1'b1) begin nFails++; $display("[TB] FAIL fall_no_irq: got %b expected 1", irq_n); end
        applyStimulus(1'b1, 1'b1, 5'h11, 8'h00);
        nChecks++; if (DO !== 8'h00) begin nFails++; $display("[TB] FAIL fall_no_flag: got %h expected 00", DO); end
        PI[7] = 1'b1;
        repeat (SS) applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 5'h11, 8'h00);
        nChecks++; if (DO !== mDO || irq_n !== 1'b0) begin nFails++; $display("[TB] FAIL collision: got %h irq %b expected %h 0", DO, irq_n, mDO); end
        applyStimulus(1'b1, 1'b1, 5'h11, 8'h00);
        nChecks++; if (DO !== 8'h40) begin nFails++; $display("[TB] FAIL collision_flag: got %h expected 40", DO); end
        applyStimulus(1'b1, 1'b0, 5'h01, 8'h80);
        repeat (2) applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
        nChecks++; if (irq_n !== 1'b1 || irq_n !== mIrqN) begin nFails++; $display("[TB] FAIL ddr_fall: got %b expected 1", irq_n); end
        applyStimulus(1'b1, 1'b0, 5'h00, 8'h80);
        applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
        nChecks++; if (irq_n !== 1'b0 || irq_n !== mIrqN) begin nFails++; $display("[TB] FAIL po_rise: got %b expected 0", irq_n); end
        applyStimulus(1'b1, 1'b0, 5'h17, 8'h00);
        nChecks++; if (irq_n !== 1'b0) begin nFails++; $display("[TB] FAIL ctl_keeps_flag: got %b expected 0", irq_n); end
        applyStimulus(1'b1, 1'b1, 5'h11, 8'h00);
        nChecks++; if (DO !== 8'h40 || irq_n !== 1'b1) begin nFails++; $display("[TB] FAIL final_flag_read: got %h irq %b expected 40 1", DO, irq_n); end
    endtask

    // Run each scenario in turn, then report.
    initial begin
        test_reset();
        test_ports();
        test_timer();
        test_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
